// File: rtl/truth_table_checker.sv
// Sweeps all 16 {w,x,y,z} vectors through an external 4-input function pair,
// samples both outputs after a settle window and checks them against expected tables.
module truth_table_checker #(
  parameter int unsigned SETTLE = 2,
  parameter logic [15:0] EXP_A  = 16'h1F55,
  parameter logic [15:0] EXP_B  = 16'h1F55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  vec_out,
  input  logic        f_a,
  input  logic        f_b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] sig_a,
  output logic [15:0] sig_b,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err_idx,
  output logic        first_err_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [3:0] idx_q;
  logic [3:0] settle_q;

  logic       accept;
  logic       settle_end;
  logic       last_vec;
  logic       mismatch;
  logic [4:0] err_next;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d    = state_q;
    accept     = start && ((state_q == IDLE) || (state_q == DONE));
    settle_end = (settle_q == SETTLE_LAST);
    last_vec   = (idx_q == 4'd15);
    mismatch   = (f_a != EXP_A[idx_q]) || (f_b != EXP_B[idx_q]);
    err_next   = err_count + 5'(mismatch);

    case (state_q)
      IDLE, DONE: if (accept) state_d = DRIVE;
      DRIVE:      if (settle_end) state_d = SAMPLE;
      SAMPLE:     state_d = last_vec ? DONE : DRIVE;
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= 4'd0;
      settle_q        <= 4'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      sig_a           <= 16'h0000;
      sig_b           <= 16'h0000;
      err_count       <= 5'd0;
      first_err_idx   <= 4'd0;
      first_err_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            idx_q           <= 4'd0;
            settle_q        <= 4'd0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            sig_a           <= 16'h0000;
            sig_b           <= 16'h0000;
            err_count       <= 5'd0;
            first_err_idx   <= 4'd0;
            first_err_valid <= 1'b0;
          end
        end

        DRIVE: settle_q <= settle_q + 4'd1;

        SAMPLE: begin
          sig_a[idx_q] <= f_a;
          sig_b[idx_q] <= f_b;
          err_count    <= err_next;
          if (mismatch && !first_err_valid) begin
            first_err_idx   <= idx_q;
            first_err_valid <= 1'b1;
          end
          // Verdict uses err_next so the last vector's result is included.
          if (last_vec) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_next == 5'd0);
          end else begin
            idx_q    <= idx_q + 4'd1;
            settle_q <= 4'd0;
          end
        end

        default: ;
      endcase
    end
  end

  assign vec_out = idx_q;

endmodule
